// File: rtl/coax_irq_pkg.sv
// Shared constants for the coax interrupt controller: per-source mode encoding
// and the largest supported source count.
package coax_irq_pkg;

    localparam logic MODE_LEVEL  = 1'b0;
    localparam logic MODE_EDGE   = 1'b1;
    localparam int   MAX_SOURCES = 16;

endpackage

// File: rtl/irq_holdoff_timer.sv
// Interrupt coalescing timer: loads on clear, counts down to zero and stays there.
// The zero flag gates the registered irq in the controller.
module irq_holdoff_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/coax_irq_controller.sv
// Parametrised interrupt controller: per-source edge/level latching, masking,
// lowest-index priority encode and a registered irq. Holdoff coalescing is
// built only when IRQ_CONTROLLER_HOLDOFF_EN is defined.
module coax_irq_controller
    import coax_irq_pkg::*;
#(
    parameter int SOURCES       = 4,
    parameter int HOLDOFF_WIDTH = 16,
    parameter int INDEX_WIDTH   = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [SOURCES-1:0]       sources,
    input  logic [SOURCES-1:0]       mask_data,
    input  logic                     mask_write_strobe,
    input  logic [SOURCES-1:0]       mode_data,
    input  logic                     mode_write_strobe,
    input  logic [SOURCES-1:0]       clear_data,
    input  logic                     clear_strobe,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_data,
    input  logic                     holdoff_write_strobe,
    output logic [SOURCES-1:0]       pending,
    output logic [INDEX_WIDTH-1:0]   active_index,
    output logic                     irq
);

    if (SOURCES < 1 || SOURCES > MAX_SOURCES) begin : g_bad_cfg
        $error("coax_irq_controller: SOURCES out of range");
    end

    logic [SOURCES-1:0]     mask_q;
    logic [SOURCES-1:0]     mode_q;
    logic [SOURCES-1:0]     prev_q;
    logic [SOURCES-1:0]     set_term;
    logic [SOURCES-1:0]     clr_term;
    logic [SOURCES-1:0]     active;
    logic [INDEX_WIDTH-1:0] enc_index;
    logic                   holdoff_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '1;
            mode_q <= {SOURCES{MODE_LEVEL}};
        end else begin
            if (mask_write_strobe) mask_q <= mask_data;
            if (mode_write_strobe) mode_q <= mode_data;
        end
    end

    // prev_q resets low so a source already high after reset reads as an edge.
    always_comb begin
        clr_term = clear_strobe ? clear_data : '0;
        for (int i = 0; i < SOURCES; i++) begin
            set_term[i] = (mode_q[i] == MODE_EDGE) ? (sources[i] & ~prev_q[i]) : sources[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= '0;
            pending <= '0;
        end else begin
            prev_q  <= sources;
            pending <= set_term | (pending & ~clr_term);
        end
    end

    assign active = pending & mask_q;

    // Scan high to low so the lowest active index is the last one assigned.
    always_comb begin
        enc_index = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (active[i]) enc_index = INDEX_WIDTH'(i);
        end
    end

`ifdef IRQ_CONTROLLER_HOLDOFF_EN
    logic [HOLDOFF_WIDTH-1:0] holdoff_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            holdoff_q <= '0;
        end else if (holdoff_write_strobe) begin
            holdoff_q <= holdoff_data;
        end
    end

    irq_holdoff_timer #(
        .WIDTH (HOLDOFF_WIDTH)
    ) u_holdoff (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (clear_strobe & (|clear_data)),
        .load_value (holdoff_q),
        .zero       (holdoff_ok)
    );
`else
    logic unused_holdoff;
    assign unused_holdoff = ^{holdoff_data, holdoff_write_strobe};
    assign holdoff_ok     = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq          <= 1'b0;
            active_index <= '0;
        end else begin
            irq          <= (|active) & holdoff_ok;
            active_index <= enc_index;
        end
    end

endmodule

// File: tb/tb_coax_irq_controller.sv
// Directed self-checking bench for coax_irq_controller (SOURCES=4); the holdoff
// scenario runs only when IRQ_CONTROLLER_HOLDOFF_EN is defined.
module tb_coax_irq_controller;

    logic        clk;
    logic        reset_n;
    logic [3:0]  sources;
    logic [3:0]  mask_data;
    logic        mask_write_strobe;
    logic [3:0]  mode_data;
    logic        mode_write_strobe;
    logic [3:0]  clear_data;
    logic        clear_strobe;
    logic [15:0] holdoff_data;
    logic        holdoff_write_strobe;
    logic [3:0]  pending;
    logic [1:0]  active_index;
    logic        irq;

    int n_chk  = 0;
    int n_pass = 0;

    coax_irq_controller #(
        .SOURCES       (4),
        .HOLDOFF_WIDTH (16)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .sources              (sources),
        .mask_data            (mask_data),
        .mask_write_strobe    (mask_write_strobe),
        .mode_data            (mode_data),
        .mode_write_strobe    (mode_write_strobe),
        .clear_data           (clear_data),
        .clear_strobe         (clear_strobe),
        .holdoff_data         (holdoff_data),
        .holdoff_write_strobe (holdoff_write_strobe),
        .pending              (pending),
        .active_index         (active_index),
        .irq                  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_data = m; mask_write_strobe = 1'b1;
        tick();
        mask_write_strobe = 1'b0;
    endtask

    task automatic write_mode(input logic [3:0] m);
        mode_data = m; mode_write_strobe = 1'b1;
        tick();
        mode_write_strobe = 1'b0;
    endtask

    task automatic do_clear(input logic [3:0] c);
        clear_data = c; clear_strobe = 1'b1;
        tick();
        clear_strobe = 1'b0; clear_data = '0;
    endtask

    initial begin
        reset_n = 1'b0; sources = '0;
        mask_data = '0; mask_write_strobe = 1'b0;
        mode_data = '0; mode_write_strobe = 1'b0;
        clear_data = '0; clear_strobe = 1'b0;
        holdoff_data = '0; holdoff_write_strobe = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_index", 32'(active_index), 32'h0);

        // Level source 1 with a clear while still high
        sources = 4'b0010;
        tick();
        chk("lvl_pending_k1", 32'(pending), 32'h2);
        chk("lvl_irq_latency", 32'(irq), 32'h0);
        tick();
        chk("lvl_irq_k2", 32'(irq), 32'h1);
        chk("lvl_index", 32'(active_index), 32'h1);
        do_clear(4'b0010);
        chk("lvl_relatch", 32'(pending), 32'h2);
        chk("lvl_irq_hold0", 32'(irq), 32'h1);
        tick();
        chk("lvl_irq_hold1", 32'(irq), 32'h1);
        sources = 4'b0000;
        tick();
        chk("lvl_pending_sticky", 32'(pending), 32'h2);
        do_clear(4'b0010);
        chk("lvl_cleared", 32'(pending), 32'h0);
        chk("lvl_irq_still", 32'(irq), 32'h1);
        tick();
        chk("lvl_irq_low", 32'(irq), 32'h0);

        // Edge mode on source 2: single-cycle pulse latches
        write_mode(4'b0100);
        sources = 4'b0100;
        tick();
        sources = 4'b0000;
        chk("edge_pending", 32'(pending), 32'h4);
        tick();
        chk("edge_irq", 32'(irq), 32'h1);
        chk("edge_index", 32'(active_index), 32'h2);
        tick(4);
        chk("edge_pending_hold", 32'(pending), 32'h4);
        chk("edge_irq_hold", 32'(irq), 32'h1);
        do_clear(4'b0100);
        tick();
        chk("edge_irq_low", 32'(irq), 32'h0);

        // Masking and priority with sources 1 and 3 pending
        sources = 4'b1010;
        tick();
        sources = 4'b0000;
        write_mask(4'b1000);
        tick();
        chk("mask_idx3", 32'(active_index), 32'h3);
        chk("mask_irq3", 32'(irq), 32'h1);
        write_mask(4'b1010);
        tick();
        chk("mask_idx1", 32'(active_index), 32'h1);
        write_mask(4'b0000);
        tick();
        chk("mask0_irq", 32'(irq), 32'h0);
        chk("mask0_idx", 32'(active_index), 32'h0);
        chk("mask0_pending", 32'(pending), 32'ha);
        write_mask(4'b0010);
        chk("unmask_next", 32'(irq), 32'h0);
        tick();
        chk("unmask_irq", 32'(irq), 32'h1);
        write_mask(4'b1111);
        do_clear(4'b1111);
        tick();
        chk("all_clear_irq", 32'(irq), 32'h0);

        // Edge on source 0 coinciding with its clear: set wins
        write_mode(4'b0001);
        sources = 4'b0001;
        clear_data = 4'b0001; clear_strobe = 1'b1;
        tick();
        clear_strobe = 1'b0; clear_data = '0;
        sources = 4'b0000;
        chk("set_wins", 32'(pending), 32'h1);
        tick();
        chk("set_wins_irq", 32'(irq), 32'h1);

        // Asynchronous reset while irq is high
        #2 reset_n = 1'b0;
        #1;
        chk("async_irq", 32'(irq), 32'h0);
        chk("async_pending", 32'(pending), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

`ifdef IRQ_CONTROLLER_HOLDOFF_EN
        begin
            int hi_cnt;
            write_mode(4'b0001);
            holdoff_data = 16'd20; holdoff_write_strobe = 1'b1;
            tick();
            holdoff_write_strobe = 1'b0;
            sources = 4'b0001;
            tick();
            sources = 4'b0000;
            tick();
            chk("ho_first_irq", 32'(irq), 32'h1);
            do_clear(4'b0001);
            // re-pulse during holdoff: pending sets but irq stays suppressed
            hi_cnt = 0;
            for (int t = 2; t <= 21; t++) begin
                sources = (t % 5 == 2) ? 4'b0001 : 4'b0000;
                tick();
                if (irq) hi_cnt++;
            end
            sources = 4'b0000;
            chk("ho_suppressed", 32'(hi_cnt), 32'h0);
            chk("ho_pending", 32'(pending), 32'h1);
            tick();
            chk("ho_reassert", 32'(irq), 32'h1);
            holdoff_data = 16'd0; holdoff_write_strobe = 1'b1;
            tick();
            holdoff_write_strobe = 1'b0;
            do_clear(4'b0001);
            sources = 4'b0001;
            tick();
            sources = 4'b0000;
            chk("ho0_latency", 32'(irq), 32'h0);
            tick();
            chk("ho0_irq", 32'(irq), 32'h1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
